stim_vector_player: RTL and testbench
=====================================

// Module: stim_vector_player
// PURPOSE
//  Synthesizable, parametrised stimulus sequencer for the AES trust-hub harnesses.
//  Holds DEPTH vectors, each a stimulus word plus an expected-response word, in an internal RAM.
//  Plays the stimulus words to the DUT (e.g. {key,state}) over a valid/ready handshake,
//    in one-shot or loop mode, and checks in-order DUT responses against the stored expectations.
//  Sits between a loader (bench or debug bus) and the DUT top.
// PARAMETERS
//  STIM_W   256  stimulus width per vector ({key[127:0],state[127:0]})
//  EXP_W    128  expected/observed response width
//  DEPTH    16   vectors in the RAM (>=2)
//  ADDR_W   $clog2(DEPTH)  vector index width (derived)
//  OUTST    4    max vectors issued but not yet observed (power of 2, >=1)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-low reset (0 = in reset)
//  load_we      in   1       write vector RAM entry
//  load_addr    in   ADDR_W  entry to write
//  load_stim    in   STIM_W  stimulus word
//  load_exp     in   EXP_W   expected response word
//  load_err     out  1       1-cycle pulse: load_we dropped because busy
//  start        in   1       begin playback from index 0 (sampled in IDLE/DONE only)
//  stop         in   1       request end of playback (loop or one-shot)
//  mode_loop    in   1       sampled at start: 1 = wrap after last_idx, 0 = one pass
//  last_idx     in   ADDR_W  sampled at start: index of final vector in a pass
//  vec_valid    out  1       stimulus word valid
//  vec_ready    in   1       DUT accepts stimulus
//  vec_data     out  STIM_W  stimulus word = RAM[play_idx].stim
//  vec_idx      out  ADDR_W  index of vec_data
//  obs_valid    in   1       DUT response valid (in issue order)
//  obs_data     in   EXP_W   DUT response
//  busy         out  1       state is PLAY or DRAIN
//  done         out  1       level: state is DONE
//  pass_cnt     out  16      completed passes (saturating)
//  err_cnt      out  16      mismatches + spurious responses (saturating at 16'hFFFF)
//  first_err    out  ADDR_W  index of first mismatch since start (valid when err_cnt!=0)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; FIFO empty; counters 0. RAM contents are NOT reset.
//  FSM states: IDLE, PLAY, DRAIN, DONE.
//   IDLE/DONE --start--> PLAY
//     On this transition: play_idx=0, err_cnt=0, pass_cnt=0, first_err=0;
//     mode_loop and last_idx are latched.
//   PLAY: vec_valid=1 unless the outstanding FIFO is full.
//     A transfer occurs when vec_valid & vec_ready; it pushes vec_idx into the FIFO.
//     Transfer at play_idx!=last_idx: play_idx++.
//     Transfer at play_idx==last_idx: pass_cnt++; then
//       loop mode: play_idx=0, stay in PLAY;
//       one-shot:  go to DRAIN.
//     stop (sampled any PLAY cycle): no further transfers after the current cycle; go to DRAIN.
//       A transfer in the same cycle as stop still completes.
//   DRAIN: vec_valid=0; go to DONE on the cycle after the FIFO becomes empty.
//   DONE: done=1 until the next start.
//  vec_data/vec_idx are combinational from play_idx.
//    They hold stable while vec_valid & !vec_ready (AXI-style: valid never drops without transfer).
//  Response check: on obs_valid, pop the FIFO head index h and compare obs_data with RAM[h].exp.
//    Mismatch: err_cnt++; first_err=h if this is the first error.
//    obs_valid with FIFO empty (including in IDLE/DONE): spurious; err_cnt++; first_err unchanged.
//  Push and pop in the same cycle are legal; FIFO occupancy is unchanged.
//  Full FIFO: vec_valid deasserts until a pop. A pop while full frees a slot for the next cycle.
//  load_we in IDLE/DONE writes RAM next edge. load_we while busy is dropped and load_err pulses.
//  start while busy: ignored. stop in IDLE/DONE: ignored.
//  last_idx >= DEPTH: clamped to DEPTH-1 at latch time.
//  Async reset mid-playback: immediate return to IDLE.
//    Outstanding responses are forgotten; later obs_valid counts as spurious.
// STRUCTURE
//  Package stim_pkg: state enum (IDLE=0, PLAY=1, DRAIN=2, DONE=3) and counter width CNT_W=16.
//  Sub-module stim_idx_fifo: OUTST-deep, ADDR_W-wide sync FIFO.
//    Ports: push, pop, din, dout, full, empty; same async active-low reset.
//  RAM: reg arrays stim_mem/exp_mem with two asynchronous read ports (play_idx and FIFO head).
// TESTING
//  1. Load 4 vectors; mode_loop=0, last_idx=3, start; vec_ready=1; DUT echoes exp 2 cycles later
//     -> 4 transfers, idx 0..3, done=1, pass_cnt=1, err_cnt=0.
//  2. Same as 1, but the response for idx 2 is corrupted -> err_cnt=1, first_err=2, done=1.
//  3. OUTST=4; vec_ready=1 with no obs_valid for 10 cycles
//     -> exactly 4 transfers, then vec_valid=0; one obs_valid -> next cycle vec_valid=1.
//  4. mode_loop=1, last_idx=1; assert stop after 5 transfers
//     -> idx sequence 0,1,0,1,0, pass_cnt=2, DRAIN, then DONE once all 5 are observed.
//  5. vec_ready toggles 1-0-1 -> vec_data/vec_idx stable while stalled, no duplicate pushes;
//     obs_valid in IDLE -> err_cnt=1.
//  6. Assert rst low mid-PLAY -> all outputs 0 immediately;
//     restart without reload -> identical results (RAM retained); load_we while busy -> load_err pulse.

Source files
------------

// File: rtl/stim_pkg.sv
// Shared types and constants for the stimulus vector player.
package stim_pkg;

    // Playback sequencer states; encodings are visible on debug taps, keep them fixed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of the pass and error counters.
    localparam int CNT_W = 16;

endpackage

// File: rtl/stim_idx_fifo.sv
// Small synchronous FIFO holding the indices of issued vectors awaiting a response.
// Push while full and pop while empty are ignored; simultaneous push/pop keeps occupancy.
module stim_idx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Pointer advance with explicit wrap so a depth of 1 works as well as powers of 2.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/stim_vector_player.sv
// Stimulus vector player: replays stored stimulus words to a DUT over valid/ready
// and scores the in-order DUT responses against the stored expected words.
module stim_vector_player
    import stim_pkg::*;
#(
    parameter int  STIM_W = 256,
    parameter int  EXP_W  = 128,
    parameter int  DEPTH  = 16,
    parameter int  OUTST  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [STIM_W-1:0] load_stim,
    input  logic [EXP_W-1:0]  load_exp,
    output logic              load_err,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_loop,
    input  logic [ADDR_W-1:0] last_idx,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic [STIM_W-1:0] vec_data,
    output logic [ADDR_W-1:0] vec_idx,
    input  logic              obs_valid,
    input  logic [EXP_W-1:0]  obs_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] play_idx;
    logic [ADDR_W-1:0] last_q;
    logic              loop_q;

    logic [STIM_W-1:0] stim_mem [DEPTH];
    logic [EXP_W-1:0]  exp_mem  [DEPTH];

    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_head;

    logic              xfer;
    logic              at_last;
    logic              start_ok;
    logic              mismatch;

    // Saturating increment for the pass and error counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == '1) return v;
        return v + CNT_W'(1);
    endfunction

    // Keep the final index of a pass inside the RAM.
    function automatic logic [ADDR_W-1:0] clamp_last(input logic [ADDR_W-1:0] idx);
        if (32'(idx) >= DEPTH) return ADDR_W'(DEPTH - 1);
        return idx;
    endfunction

    assign busy      = (state_q == PLAY) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign xfer      = vec_valid && vec_ready;
    assign at_last   = (play_idx == last_q);
    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
    assign mismatch  = (obs_data != exp_mem[fifo_head]);

    // Stimulus is only presented while playing so idle outputs read as zero.
    assign vec_data  = (state_q == PLAY) ? stim_mem[play_idx] : '0;
    assign vec_idx   = (state_q == PLAY) ? play_idx : '0;

    // Issued-but-unanswered indices, popped by each response in issue order.
    stim_idx_fifo #(
        .DEPTH (OUTST),
        .W     (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (xfer),
        .pop   (obs_valid),
        .din   (play_idx),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and handshake valid; a full FIFO throttles issue.
    always_comb begin
        state_d   = state_q;
        vec_valid = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = PLAY;
            end
            PLAY: begin
                vec_valid = !fifo_full;
                if (stop)                                 state_d = DRAIN;
                else if (xfer && vec_valid && at_last && !loop_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Playback index, latched run configuration, counters and load error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            play_idx  <= '0;
            last_q    <= '0;
            loop_q    <= 1'b0;
            pass_cnt  <= '0;
            err_cnt   <= '0;
            first_err <= '0;
            load_err  <= 1'b0;
        end else begin
            load_err <= load_we && busy;
            if (start_ok) begin
                play_idx  <= '0;
                pass_cnt  <= '0;
                err_cnt   <= '0;
                first_err <= '0;
                loop_q    <= mode_loop;
                last_q    <= clamp_last(last_idx);
            end else begin
                if (xfer) begin
                    if (at_last) begin
                        pass_cnt <= sat_inc(pass_cnt);
                        play_idx <= '0;
                    end else begin
                        play_idx <= play_idx + ADDR_W'(1);
                    end
                end
                if (obs_valid) begin
                    if (fifo_empty) begin
                        err_cnt <= sat_inc(err_cnt);
                    end else if (mismatch) begin
                        err_cnt <= sat_inc(err_cnt);
                        if (err_cnt == '0) first_err <= fifo_head;
                    end
                end
            end
        end
    end

    // Vector RAM writes; only accepted while not playing, contents survive reset.
    always_ff @(posedge clk) begin
        if (load_we && !busy) begin
            stim_mem[load_addr] <= load_stim;
            exp_mem[load_addr]  <= load_exp;
        end
    end

endmodule

// File: tb/tb_stim_vector_player.sv
// Directed bench for stim_vector_player: a mock DUT echoes a function of each
// accepted stimulus word two cycles later; each scenario checks its own results.
module tb_stim_vector_player;

    localparam int STIM_W = 16;
    localparam int EXP_W  = 8;
    localparam int DEPTH  = 12;
    localparam int OUTST  = 4;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load_we = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [STIM_W-1:0] load_stim = '0;
    logic [EXP_W-1:0]  load_exp = '0;
    logic              load_err;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              mode_loop = 1'b0;
    logic [ADDR_W-1:0] last_idx = '0;
    logic              vec_valid;
    logic              vec_ready = 1'b0;
    logic [STIM_W-1:0] vec_data;
    logic [ADDR_W-1:0] vec_idx;
    logic              obs_valid = 1'b0;
    logic [EXP_W-1:0]  obs_data = '0;
    logic              busy;
    logic              done;
    logic [15:0]       pass_cnt;
    logic [15:0]       err_cnt;
    logic [ADDR_W-1:0] first_err;

    int total = 0;
    int bad = 0;

    int               xlog[$];
    logic             dly_v [2];
    logic [EXP_W-1:0] dly_d [2];
    bit               echo_en = 1'b0;
    int               corrupt_n = -1;

    always #5 clk = ~clk;

    stim_vector_player #(
        .STIM_W (STIM_W),
        .EXP_W  (EXP_W),
        .DEPTH  (DEPTH),
        .OUTST  (OUTST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_stim (load_stim),
        .load_exp  (load_exp),
        .load_err  (load_err),
        .start     (start),
        .stop      (stop),
        .mode_loop (mode_loop),
        .last_idx  (last_idx),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_data  (vec_data),
        .vec_idx   (vec_idx),
        .obs_valid (obs_valid),
        .obs_data  (obs_data),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

    function automatic logic [STIM_W-1:0] stim_of(input int i);
        return 16'(32'hC0DE + i * 32'h1357);
    endfunction

    function automatic logic [EXP_W-1:0] exp_of(input logic [STIM_W-1:0] s);
        return s[15:8] ^ s[7:0] ^ 8'h5A;
    endfunction

    // One clock: log a transfer, run the mock DUT delay line, then move to the next negedge.
    task automatic tick();
        logic             xf;
        logic [EXP_W-1:0] r;
        xf = vec_valid && vec_ready;
        r  = exp_of(vec_data);
        if (corrupt_n == xlog.size()) r = r ^ 8'h01;
        if (xf) xlog.push_back(int'(vec_idx));
        if (echo_en) begin
            obs_valid = dly_v[1];
            obs_data  = dly_d[1];
        end
        dly_v[1] = dly_v[0];
        dly_d[1] = dly_d[0];
        dly_v[0] = xf;
        dly_d[0] = r;
        @(negedge clk);
    endtask

    task automatic set_echo(input bit en);
        echo_en   = en;
        dly_v[0]  = 1'b0;
        dly_v[1]  = 1'b0;
        obs_valid = 1'b0;
        obs_data  = '0;
    endtask

    task automatic do_start(input bit loop, input logic [ADDR_W-1:0] last);
        mode_loop = loop;
        last_idx  = last;
        start     = 1'b1;
        xlog.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        for (int i = 0; i < max && done !== 1'b1; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL reset_vec_valid: got %b want 0", vec_valid); end
        total++; if (vec_data !== '0) begin bad++; $display("FAIL reset_vec_data: got %h want 0", vec_data); end
        total++; if ({busy, done, load_err} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, load_err}); end
        total++; if ({pass_cnt, err_cnt} !== 32'h0) begin bad++; $display("FAIL reset_counts: got %h want 0", {pass_cnt, err_cnt}); end
        rst = 1'b1;
        @(negedge clk);
        set_echo(1'b1);
    endtask

    task automatic load_all();
        for (int i = 0; i < DEPTH; i++) begin
            load_we   = 1'b1;
            load_addr = ADDR_W'(i);
            load_stim = stim_of(i);
            load_exp  = exp_of(stim_of(i));
            tick();
        end
        load_we = 1'b0;
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL load_idle_err: got %b want 0", load_err); end
    endtask

    task automatic test_one_shot();
        vec_ready = 1'b1;
        do_start(1'b0, 4'd3);
        wait_done(40);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL one_shot_done: got %b want 1", done); end
        total++; if (xlog.size() !== 4) begin bad++; $display("FAIL one_shot_count: got %0d want 4", xlog.size()); end
        for (int i = 0; i < xlog.size() && i < 4; i++) begin
            total++; if (xlog[i] !== i) begin bad++; $display("FAIL one_shot_idx%0d: got %0d want %0d", i, xlog[i], i); end
        end
        total++; if (pass_cnt !== 16'd1) begin bad++; $display("FAIL one_shot_pass: got %0d want 1", pass_cnt); end
        total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL one_shot_err: got %0d want 0", err_cnt); end
        total++; if ({vec_valid, busy} !== 2'b00) begin bad++; $display("FAIL one_shot_idle_out: got %b want 00", {vec_valid, busy}); end
    endtask

    task automatic test_mismatch();
        corrupt_n = 2;
        vec_ready = 1'b1;
        do_start(1'b0, 4'd3);
        wait_done(40);
        corrupt_n = -1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mismatch_done: got %b want 1", done); end
        total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL mismatch_err: got %0d want 1", err_cnt); end
        total++; if (first_err !== 4'd2) begin bad++; $display("FAIL mismatch_first: got %0d want 2", first_err); end
        total++; if (pass_cnt !== 16'd1) begin bad++; $display("FAIL mismatch_pass: got %0d want 1", pass_cnt); end
    endtask

    task automatic test_full();
        set_echo(1'b0);
        vec_ready = 1'b1;
        do_start(1'b0, 4'd7);
        repeat (10) tick();
        total++; if (xlog.size() !== 4) begin bad++; $display("FAIL full_count: got %0d want 4", xlog.size()); end
        total++; if (vec_valid !== 1'b0) begin bad++; $display("FAIL full_valid_low: got %b want 0", vec_valid); end
        obs_valid = 1'b1;
        obs_data  = exp_of(stim_of(0));
        tick();
        obs_valid = 1'b0;
        total++; if (vec_valid !== 1'b1) begin bad++; $display("FAIL full_valid_back: got %b want 1", vec_valid); end
        total++; if (vec_idx !== 4'd4) begin bad++; $display("FAIL full_next_idx: got %0d want 4", vec_idx); end
        vec_ready = 1'b0;
        stop      = 1'b1;
        tick();
        stop = 1'b0;
        total++; if ({busy, vec_valid} !== 2'b10) begin bad++; $display("FAIL full_drain: got %b want 10", {busy, vec_valid}); end
        for (int k = 1; k <= 3; k++) begin
            obs_valid = 1'b1;
            obs_data  = exp_of(stim_of(k));
            tick();
        end
        obs_valid = 1'b0;
        wait_done(10);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done: got %b want 1", done); end
        total++; if ({pass_cnt, err_cnt} !== 32'h0) begin bad++; $display("FAIL full_counts: got %h want 0", {pass_cnt, err_cnt}); end
        set_echo(1'b1);
    endtask

    task automatic test_loop_stop();
        int exp_seq[5] = '{0, 1, 0, 1, 0};
        vec_ready = 1'b1;
        do_start(1'b1, 4'd1);
        for (int i = 0; i < 20; i++) begin
            if (xlog.size() == 4) stop = 1'b1;
            tick();
            if (stop) begin
                stop = 1'b0;
                break;
            end
        end
        total++; if ({busy, done, vec_valid} !== 3'b100) begin bad++; $display("FAIL loop_drain: got %b want 100", {busy, done, vec_valid}); end
        total++; if (pass_cnt !== 16'd2) begin bad++; $display("FAIL loop_pass: got %0d want 2", pass_cnt); end
        wait_done(20);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL loop_done: got %b want 1", done); end
        total++; if (xlog.size() !== 5) begin bad++; $display("FAIL loop_count: got %0d want 5", xlog.size()); end
        for (int i = 0; i < xlog.size() && i < 5; i++) begin
            total++; if (xlog[i] !== exp_seq[i]) begin bad++; $display("FAIL loop_idx%0d: got %0d want %0d", i, xlog[i], exp_seq[i]); end
        end
        total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL loop_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_stall();
        vec_ready = 1'b0;
        do_start(1'b0, 4'd3);
        tick();
        total++; if ({vec_valid, vec_idx} !== {1'b1, 4'd0}) begin bad++; $display("FAIL stall_hold_idx: got %b/%0d want 1/0", vec_valid, vec_idx); end
        total++; if (vec_data !== stim_of(0)) begin bad++; $display("FAIL stall_hold_data: got %h want %h", vec_data, stim_of(0)); end
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        tick();
        total++; if (vec_idx !== 4'd1) begin bad++; $display("FAIL stall_hold_idx1: got %0d want 1", vec_idx); end
        total++; if (vec_data !== stim_of(1)) begin bad++; $display("FAIL stall_hold_data1: got %h want %h", vec_data, stim_of(1)); end
        total++; if (xlog.size() !== 1) begin bad++; $display("FAIL stall_no_dup: got %0d want 1", xlog.size()); end
        vec_ready = 1'b1;
        wait_done(40);
        total++; if (xlog.size() !== 4) begin bad++; $display("FAIL stall_count: got %0d want 4", xlog.size()); end
        for (int i = 0; i < xlog.size() && i < 4; i++) begin
            total++; if (xlog[i] !== i) begin bad++; $display("FAIL stall_idx%0d: got %0d want %0d", i, xlog[i], i); end
        end
        total++; if ({done, err_cnt} !== {1'b1, 16'd0}) begin bad++; $display("FAIL stall_result: got %b/%0d want 1/0", done, err_cnt); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        set_echo(1'b0);
        obs_valid = 1'b1;
        obs_data  = 8'h00;
        tick();
        obs_valid = 1'b0;
        total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL spurious_err: got %0d want 1", err_cnt); end
        total++; if ({done, busy, first_err} !== {2'b00, 4'd0}) begin bad++; $display("FAIL spurious_state: got %b/%0d want 00/0", {done, busy}, first_err); end
        set_echo(1'b1);
    endtask

    task automatic test_reset_mid();
        vec_ready = 1'b1;
        do_start(1'b0, 4'd7);
        tick();
        tick();
        load_we   = 1'b1;
        load_addr = 4'd0;
        load_stim = 16'hFFFF;
        load_exp  = 8'h00;
        tick();
        load_we = 1'b0;
        total++; if (load_err !== 1'b1) begin bad++; $display("FAIL load_busy_err: got %b want 1", load_err); end
        tick();
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL load_err_pulse: got %b want 0", load_err); end
        total++; if ({busy, vec_valid} !== 2'b11) begin bad++; $display("FAIL mid_play: got %b want 11", {busy, vec_valid}); end
        rst = 1'b0;
        #1;
        total++; if ({vec_valid, busy, done, load_err} !== 4'b0000) begin bad++; $display("FAIL rst_mid_flags: got %b want 0000", {vec_valid, busy, done, load_err}); end
        total++; if ({vec_data, vec_idx} !== '0) begin bad++; $display("FAIL rst_mid_vec: got %h/%0d want 0/0", vec_data, vec_idx); end
        total++; if ({pass_cnt, err_cnt, first_err} !== '0) begin bad++; $display("FAIL rst_mid_counts: got %h want 0", {pass_cnt, err_cnt, first_err}); end
        @(negedge clk);
        rst = 1'b1;
        set_echo(1'b1);
        do_start(1'b0, 4'd3);
        wait_done(40);
        total++; if (xlog.size() !== 4) begin bad++; $display("FAIL restart_count: got %0d want 4", xlog.size()); end
        total++; if ({done, pass_cnt, err_cnt} !== {1'b1, 16'd1, 16'd0}) begin bad++; $display("FAIL restart_result: got %b/%0d/%0d want 1/1/0", done, pass_cnt, err_cnt); end
    endtask

    task automatic test_clamp();
        vec_ready = 1'b1;
        do_start(1'b0, 4'd15);
        wait_done(80);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL clamp_done: got %b want 1", done); end
        total++; if (xlog.size() !== DEPTH) begin bad++; $display("FAIL clamp_count: got %0d want %0d", xlog.size(), DEPTH); end
        for (int i = 0; i < xlog.size() && i < DEPTH; i++) begin
            total++; if (xlog[i] !== i) begin bad++; $display("FAIL clamp_idx%0d: got %0d want %0d", i, xlog[i], i); end
        end
        total++; if ({pass_cnt, err_cnt} !== {16'd1, 16'd0}) begin bad++; $display("FAIL clamp_counts: got %0d/%0d want 1/0", pass_cnt, err_cnt); end
    endtask

    initial begin
        test_reset();
        load_all();
        test_one_shot();
        test_mismatch();
        test_full();
        test_loop_stop();
        test_stall();
        test_reset_mid();
        test_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
